rob_ctrl: RTL and testbench

ROB_CTRL -- requirements
Module: rob_ctrl

---
 rtl/rob_if.sv | 26 ++
 rtl/rob_ctrl.sv | 122 ++++++++++++
 tb/tb_rob_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/rob_if.sv
// Decode / CDB / commit bundle of the reorder-buffer controller.
// alloc_i is accepted only in a cycle where stall_o is low; commitAck_i retires only in a cycle where commitValid_o is high.
interface rob_if #(
    parameter int TW = 6
);
    logic          alloc_i;
    logic [TW-1:0] allocTag_o;
    logic          stall_o;
    logic          doneValid_i;
    logic [TW-1:0] doneTag_i;
    logic [TW-1:0] headTag_o;
    logic          commitValid_o;
    logic          commitAck_i;
    logic          flush_i;
    logic [TW-1:0] count_o;

    modport master (
        output alloc_i, doneValid_i, doneTag_i, commitAck_i, flush_i,
        input  allocTag_o, stall_o, headTag_o, commitValid_o, count_o
    );

    modport slave (
        input  alloc_i, doneValid_i, doneTag_i, commitAck_i, flush_i,
        output allocTag_o, stall_o, headTag_o, commitValid_o, count_o
    );
endinterface

// File: rtl/rob_ctrl.sv
// Reorder-buffer bookkeeping: per-entry occupied/done bits, circular head/tail tags 1..ROBsize
// (tag 0 means "value in regfile"), and a one-cycle flush state after a mispredict.
module rob_ctrl #(
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
    input  logic  clk_i,
    input  logic  reset_i,
    rob_if.slave  rob,
    output logic  dbg_state_o
);
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam logic [ROBsizeLog-1:0] TAG_ONE = ROBsizeLog'(1);
    localparam logic [ROBsizeLog-1:0] TAG_MAX = ROBsizeLog'(ROBsize);

    state_e                state_q, state_d;
    logic [ROBsize:0]      occ_q, occ_d;
    logic [ROBsize:0]      done_q, done_d;
    logic [ROBsizeLog-1:0] head_q, head_d;
    logic [ROBsizeLog-1:0] tail_q, tail_d;
    logic [ROBsizeLog-1:0] count_q, count_d;

    logic stall;
    logic commit_valid;
    logic do_alloc;
    logic do_retire;
    logic done_hit;

    function automatic logic [ROBsizeLog-1:0] next_tag(input logic [ROBsizeLog-1:0] t);
        return (t == TAG_MAX) ? TAG_ONE : t + TAG_ONE;
    endfunction

    always_comb begin
        stall        = (count_q == TAG_MAX) || (state_q == ST_FLUSH);
        commit_valid = (state_q == ST_RUN) && occ_q[head_q] && done_q[head_q];
        do_alloc     = rob.alloc_i && !stall;
        do_retire    = rob.commitAck_i && commit_valid;

        // A completion for the slot being allocated this cycle is stale; the new entry starts not done.
        done_hit = 1'b0;
        if (rob.doneValid_i && (rob.doneTag_i != '0) && (rob.doneTag_i <= TAG_MAX)) begin
            if (occ_q[rob.doneTag_i] && !(do_alloc && (rob.doneTag_i == tail_q))) begin
                done_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        case (state_q)
            ST_RUN: begin
                if (rob.flush_i) begin
                    state_d = ST_FLUSH;
                    occ_d   = '0;
                    done_d  = '0;
                    head_d  = TAG_ONE;
                    tail_d  = TAG_ONE;
                    count_d = '0;
                end else begin
                    if (done_hit) begin
                        done_d[rob.doneTag_i] = 1'b1;
                    end
                    if (do_retire) begin
                        occ_d[head_q] = 1'b0;
                        head_d        = next_tag(head_q);
                    end
                    if (do_alloc) begin
                        occ_d[tail_q]  = 1'b1;
                        done_d[tail_q] = 1'b0;
                        tail_d         = next_tag(tail_q);
                    end
                    case ({do_alloc, do_retire})
                        2'b10:   count_d = count_q + TAG_ONE;
                        2'b01:   count_d = count_q - TAG_ONE;
                        default: count_d = count_q;
                    endcase
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
            occ_q   <= '0;
            done_q  <= '0;
            head_q  <= TAG_ONE;
            tail_q  <= TAG_ONE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rob.allocTag_o    = tail_q;
    assign rob.headTag_o     = head_q;
    assign rob.stall_o       = stall;
    assign rob.commitValid_o = commit_valid;
    assign rob.count_o       = count_q;
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl with an 8-entry ROB: directed vector table, then random traffic
// checked against an in-order queue model of the ROB.
module tb_rob_ctrl;
    localparam int N  = 8;
    localparam int TW = 4;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;
    logic dbg_state_o;

    rob_if #(.TW(TW)) bus ();

    rob_ctrl #(.ROBsize(N), .ROBsizeLog(TW)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rob         (bus),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit rst, al, dv, ak, fl;
        int dt;
        int e_atag, e_head, e_cnt;
        bit e_stall, e_cv;
    } vec_t;

    vec_t vecs[$];

    // In-order model: oldest entry at the front of the queue.
    typedef struct {
        int tag;
        bit done;
    } ent_t;

    ent_t m_q[$];
    int   m_tail  = 1;
    bit   m_flush = 1'b0;

    task automatic add(input bit rst, input bit al, input bit dv, input int dt, input bit ak,
                       input bit fl, input int atag, input int head, input int cnt,
                       input bit st, input bit cv);
        vec_t v;
        v.rst = rst; v.al = al; v.dv = dv; v.dt = dt; v.ak = ak; v.fl = fl;
        v.e_atag = atag; v.e_head = head; v.e_cnt = cnt; v.e_stall = st; v.e_cv = cv;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit rst, input bit al, input bit dv, input int dt,
                         input bit ak, input bit fl);
        reset_i         = rst;
        bus.alloc_i     = al;
        bus.doneValid_i = dv;
        bus.doneTag_i   = TW'(dt);
        bus.commitAck_i = ak;
        bus.flush_i     = fl;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_outputs(input string tag, input int atag, input int head, input int cnt,
                                 input bit st, input bit cv);
        check({tag, ".allocTag"},    int'(bus.allocTag_o),    atag);
        check({tag, ".headTag"},     int'(bus.headTag_o),     head);
        check({tag, ".count"},       int'(bus.count_o),       cnt);
        check({tag, ".stall"},       int'(bus.stall_o),       int'(st));
        check({tag, ".commitValid"}, int'(bus.commitValid_o), int'(cv));
    endtask

    task automatic model_step(input bit rst, input bit al, input bit dv, input int dt,
                              input bit ak, input bit fl);
        bit do_al, do_rt;
        if (rst) begin
            m_q.delete(); m_tail = 1; m_flush = 1'b0;
        end else if (m_flush) begin
            m_flush = 1'b0;
        end else if (fl) begin
            m_q.delete(); m_tail = 1; m_flush = 1'b1;
        end else begin
            do_al = al && (m_q.size() < N);
            do_rt = ak && (m_q.size() > 0) && m_q[0].done;
            if (dv) begin
                foreach (m_q[i]) if (m_q[i].tag == dt) m_q[i].done = 1'b1;
            end
            if (do_rt) void'(m_q.pop_front());
            if (do_al) begin
                m_q.push_back('{tag: m_tail, done: 1'b0});
                m_tail = (m_tail == N) ? 1 : m_tail + 1;
            end
        end
    endtask

    task automatic model_check(input string tag);
        int  head;
        bit  cv;
        head = (m_q.size() > 0) ? m_q[0].tag : m_tail;
        cv   = !m_flush && (m_q.size() > 0) && m_q[0].done;
        check_outputs(tag, m_tail, head, m_q.size(), (m_q.size() == N) || m_flush, cv);
    endtask

    initial begin
        bus.alloc_i = 1'b0; bus.doneValid_i = 1'b0; bus.doneTag_i = '0;
        bus.commitAck_i = 1'b0; bus.flush_i = 1'b0;

        //   rst al dv dt ak fl   atag head cnt st cv
        add(1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,   2, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0,   3, 1, 2, 0, 0);
        add(0, 1, 0, 0, 0, 0,   4, 1, 3, 0, 0);
        add(0, 1, 0, 0, 0, 0,   5, 1, 4, 0, 0);
        add(0, 1, 0, 0, 0, 0,   6, 1, 5, 0, 0);
        add(0, 1, 0, 0, 0, 0,   7, 1, 6, 0, 0);
        add(0, 1, 0, 0, 0, 0,   8, 1, 7, 0, 0);
        add(0, 1, 0, 0, 0, 0,   1, 1, 8, 1, 0);
        add(0, 1, 0, 0, 0, 0,   1, 1, 8, 1, 0);  // alloc while full ignored
        add(0, 0, 1, 1, 0, 0,   1, 1, 8, 1, 1);
        add(0, 0, 0, 0, 1, 0,   1, 2, 7, 0, 0);  // retire while full
        add(1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,   2, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0,   3, 1, 2, 0, 0);
        add(0, 0, 1, 2, 0, 0,   3, 1, 2, 0, 0);  // out-of-order completion
        add(0, 0, 1, 1, 0, 0,   3, 1, 2, 0, 1);
        add(0, 0, 0, 0, 1, 0,   3, 2, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0,   3, 3, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0,   3, 3, 0, 0, 0);  // ack without valid
        add(0, 1, 0, 0, 0, 0,   4, 3, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0,   5, 3, 2, 0, 0);
        add(0, 1, 0, 0, 0, 0,   6, 3, 3, 0, 0);
        add(0, 1, 0, 0, 0, 0,   7, 3, 4, 0, 0);
        add(0, 0, 1, 3, 0, 0,   7, 3, 4, 0, 1);
        add(0, 1, 0, 0, 1, 0,   8, 4, 4, 0, 0);  // alloc + retire
        add(0, 1, 0, 0, 0, 0,   1, 4, 5, 0, 0);
        add(0, 0, 0, 0, 0, 1,   1, 1, 0, 1, 0);  // flush
        add(0, 1, 1, 3, 1, 1,   1, 1, 0, 0, 0);  // all inputs ignored in flush
        add(0, 0, 1, 3, 0, 0,   1, 1, 0, 0, 0);  // stale tag
        add(0, 1, 1, 0, 0, 0,   2, 1, 1, 0, 0);  // tag 0
        add(0, 1, 1, 2, 0, 0,   3, 1, 2, 0, 0);  // done for tag being allocated
        add(0, 0, 1, 5, 0, 0,   3, 1, 2, 0, 0);  // unoccupied tag
        add(0, 0, 1, 12, 0, 0,  3, 1, 2, 0, 0);  // tag beyond ROB
        add(0, 0, 1, 1, 0, 0,   3, 1, 2, 0, 1);
        add(0, 0, 0, 0, 1, 0,   3, 2, 1, 0, 0);
        add(1, 1, 1, 2, 1, 1,   1, 1, 0, 0, 0);  // reset priority
        add(0, 0, 0, 0, 0, 1,   1, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);  // reset mid-flush
        add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);

        @(negedge clk_i);
        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].al, vecs[i].dv, vecs[i].dt, vecs[i].ak, vecs[i].fl);
            check_outputs($sformatf("vec%0d", i), vecs[i].e_atag, vecs[i].e_head,
                          vecs[i].e_cnt, vecs[i].e_stall, vecs[i].e_cv);
        end

        // Hand sequence: fill, retire one, refill in the same cycle as the next retire.
        apply(1, 0, 0, 0, 0, 0); model_step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) begin
            apply(0, 1, 1, (i == 0) ? 0 : i, 0, 0); model_step(0, 1, 1, (i == 0) ? 0 : i, 0, 0);
        end
        model_check("fill");
        apply(0, 1, 0, 0, 1, 0); model_step(0, 1, 0, 0, 1, 0);
        model_check("full_retire");
        apply(0, 1, 0, 0, 1, 0); model_step(0, 1, 0, 0, 1, 0);
        model_check("refill_retire");

        // Random traffic against the queue model.
        apply(1, 0, 0, 0, 0, 0); model_step(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            bit rst, al, dv, ak, fl;
            int dt;
            rst = ($urandom_range(0, 199) == 0);
            fl  = ($urandom_range(0, 49) == 0);
            al  = ($urandom_range(0, 9) < 6);
            ak  = ($urandom_range(0, 9) < 5);
            dv  = ($urandom_range(0, 9) < 6);
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
                dt = m_q[$urandom_range(0, m_q.size() - 1)].tag;
            else
                dt = $urandom_range(0, 15);
            apply(rst, al, dv, dt, ak, fl);
            model_step(rst, al, dv, dt, ak, fl);
            model_check($sformatf("rand%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
